ql_episode_controller: RTL and testbench

Sequencing controller for the Q-learning agent datapath. It runs training episodes against an external environment model through a valid/ready handshake and presents each observed state and reward to the agent. It pulses the agent update enable, waits out the agent's fixed latency, and issues the chosen action back to the environment. It also counts steps and episodes, detects terminal conditions, and schedules epsilon per episode.

---
 rtl/ql_episode_controller.sv | 122 ++++++++++++
 tb/tb_ql_episode_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ql_episode_controller.sv
// ql_episode_controller: sequences Q-learning episodes between environment and agent
// Ports: clk/rst (async active-high); run level; obs_* observation handshake in;
// act_* action handshake out; agent_* update strobe, latched state/reward, epsilon, action in;
// step/episode/goal counters; busy/done status.
// Optional feature: define EPSILON_DECAY_EN to decay epsilon at every episode end.
module ql_episode_controller #(
    parameter int          MAX_STEPS       = 64,
    parameter int          NUM_EPISODES    = 1000,
    parameter logic [5:0]  GOAL_STATE      = 6'd63,
    parameter int          AGENT_LATENCY   = 2,
    parameter logic [15:0] EPS_INIT        = 16'hE666,
    parameter logic [15:0] EPS_MIN         = 16'h0CCC,
    parameter int          EPS_DECAY_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        obs_valid,
    output logic        obs_ready,
    input  logic [5:0]  obs_state,
    input  logic [15:0] obs_reward,
    output logic        env_reset,
    output logic        act_valid,
    input  logic        act_ready,
    output logic [3:0]  act_data,
    output logic        agent_en,
    output logic        agent_start,
    output logic [5:0]  agent_next_state,
    output logic [15:0] agent_next_reward,
    output logic [15:0] agent_epsilon,
    input  logic [3:0]  agent_next_action,
    output logic [15:0] step_count,
    output logic [15:0] episode_count,
    output logic [15:0] goal_count,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, RESET_ENV, WAIT_OBS, UPDATE, WAIT_AGENT, ISSUE_ACT, EP_END, DONE} state_t;
    state_t state;
    logic [15:0] lat_cnt;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction
    // handshake readiness is gated by run so an abort withdraws it in the same cycle
    assign obs_ready   = run && state == WAIT_OBS;
    assign act_valid   = run && state == ISSUE_ACT;
    assign env_reset   = state == RESET_ENV;
    assign agent_en    = state == UPDATE;
    assign agent_start = agent_en && step_count == 16'd0;
    assign busy        = state != IDLE && state != DONE;
    assign done        = state == DONE;
`ifdef EPSILON_DECAY_EN
    logic [15:0] eps_dec;
    assign eps_dec = agent_epsilon - (agent_epsilon >> EPS_DECAY_SHIFT);
`else
    assign agent_epsilon = EPS_INIT;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            lat_cnt           <= '0;
            act_data          <= '0;
            agent_next_state  <= '0;
            agent_next_reward <= '0;
            step_count        <= '0;
            episode_count     <= '0;
            goal_count        <= '0;
`ifdef EPSILON_DECAY_EN
            agent_epsilon     <= EPS_INIT;
`endif
        end else if (state != IDLE && !run) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (run) begin
                    step_count    <= '0;
                    episode_count <= '0;
                    goal_count    <= '0;
`ifdef EPSILON_DECAY_EN
                    agent_epsilon <= EPS_INIT;
`endif
                    state         <= RESET_ENV;
                end
                RESET_ENV: begin
                    step_count <= '0;
                    state      <= WAIT_OBS;
                end
                WAIT_OBS: if (obs_valid) begin
                    agent_next_state  <= obs_state;
                    agent_next_reward <= obs_reward;
                    state             <= UPDATE;
                end
                UPDATE: begin
                    lat_cnt <= '0;
                    state   <= WAIT_AGENT;
                end
                WAIT_AGENT: begin
                    lat_cnt <= lat_cnt + 16'd1;
                    // the agent's action is valid on the last latency cycle
                    if (lat_cnt == 16'(AGENT_LATENCY - 1)) begin
                        act_data <= agent_next_action;
                        state    <= (agent_next_state == GOAL_STATE || step_count == 16'(MAX_STEPS - 1)) ? EP_END : ISSUE_ACT;
                    end
                end
                ISSUE_ACT: if (act_ready) begin
                    step_count <= sat_inc(step_count);
                    state      <= WAIT_OBS;
                end
                EP_END: begin
                    episode_count <= sat_inc(episode_count);
                    if (agent_next_state == GOAL_STATE) goal_count <= sat_inc(goal_count);
`ifdef EPSILON_DECAY_EN
                    agent_epsilon <= eps_dec < EPS_MIN ? EPS_MIN : eps_dec;
`endif
                    state <= episode_count == 16'(NUM_EPISODES - 1) ? DONE : RESET_ENV;
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ql_episode_controller.sv
// tb_ql_episode_controller: randomized episode-level checks of ql_episode_controller
module tb_ql_episode_controller;
    localparam int          MS = 4;
    localparam int          NE = 4;
    localparam int          L  = 2;
    localparam int          SH = 1;
    localparam logic [15:0] EI = 16'h8000;
    localparam logic [15:0] EM = 16'h1000;
    localparam logic [5:0]  GS = 6'd63;

    logic        clk = 0, rst, run, obs_valid, obs_ready, env_reset, act_valid, act_ready;
    logic        agent_en, agent_start, busy, done;
    logic [5:0]  obs_state, agent_next_state;
    logic [15:0] obs_reward, agent_next_reward, agent_epsilon, step_count, episode_count, goal_count;
    logic [3:0]  act_data, agent_next_action;

    always #5 clk = ~clk;

    ql_episode_controller #(
        .MAX_STEPS(MS), .NUM_EPISODES(NE), .GOAL_STATE(GS), .AGENT_LATENCY(L),
        .EPS_INIT(EI), .EPS_MIN(EM), .EPS_DECAY_SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .obs_valid(obs_valid), .obs_ready(obs_ready),
        .obs_state(obs_state), .obs_reward(obs_reward), .env_reset(env_reset),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .agent_en(agent_en), .agent_start(agent_start), .agent_next_state(agent_next_state),
        .agent_next_reward(agent_next_reward), .agent_epsilon(agent_epsilon),
        .agent_next_action(agent_next_action), .step_count(step_count),
        .episode_count(episode_count), .goal_count(goal_count), .busy(busy), .done(done)
    );

    int          n_chk = 0, n_fail = 0;
    int          steps, episodes, goals;
    logic [15:0] eps;
    logic [3:0]  na;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] decay(input logic [15:0] e);
`ifdef EPSILON_DECAY_EN
        int d;
        d = int'(e) - int'(e) / (2 ** SH);
        return d < int'(EM) ? EM : 16'(d);
`else
        return e;
`endif
    endfunction

    // one observation -> update -> action (or episode end) step of the model
    task automatic do_step(input logic [5:0] s, input logic [15:0] r, input int hold);
        bit term;
        repeat ($urandom_range(0, 2)) begin
            chk("obs_ready_wait", obs_ready, 1);
            tick;
        end
        obs_state = s; obs_reward = r; obs_valid = 1;
        chk("obs_ready", obs_ready, 1);
        chk("act_valid_in_obs", act_valid, 0);
        tick;
        obs_valid = 0;
        chk("agent_en", agent_en, 1);
        chk("agent_start", agent_start, steps == 0);
        chk("next_state", agent_next_state, s);
        chk("next_reward", agent_next_reward, r);
        chk("obs_ready_update", obs_ready, 0);
        term = (s == GS) || (steps == MS - 1);
        for (int i = 0; i < L; i++) begin
            tick;
            chk("agent_en_low", agent_en, 0);
            chk("act_valid_wait", act_valid, 0);
            na = 4'($urandom);
            agent_next_action = na;
            obs_valid = 1'($urandom);
            obs_state = 6'($urandom);
            act_ready = 1'($urandom);
        end
        tick;
        obs_valid = 0; act_ready = 0;
        chk("next_state_hold", agent_next_state, s);
        chk("next_reward_hold", agent_next_reward, r);
        if (!term) begin
            chk("act_valid", act_valid, 1);
            chk("act_data", act_data, na);
            repeat (hold) begin
                agent_next_action = 4'($urandom);
                tick;
                chk("act_valid_hold", act_valid, 1);
                chk("act_data_hold", act_data, na);
                chk("step_hold", step_count, steps);
            end
            act_ready = 1;
            tick;
            act_ready = 0;
            steps++;
            chk("step_inc", step_count, steps);
            chk("obs_ready_next", obs_ready, 1);
            chk("act_valid_drop", act_valid, 0);
        end else begin
            chk("act_valid_term", act_valid, 0);
            chk("busy_ep_end", busy, 1);
            episodes++;
            if (s == GS) goals++;
            eps = decay(eps);
            tick;
            chk("episode_count", episode_count, episodes);
            chk("goal_count", goal_count, goals);
            chk("epsilon", agent_epsilon, eps);
            if (episodes == NE) begin
                chk("done", done, 1);
                chk("busy_done", busy, 0);
                chk("env_reset_done", env_reset, 0);
            end else begin
                chk("env_reset_ep", env_reset, 1);
                tick;
                steps = 0;
                chk("step_clear", step_count, 0);
                chk("env_reset_once", env_reset, 0);
            end
        end
    endtask

    initial begin
        rst = 1; run = 0; obs_valid = 0; act_ready = 0; obs_state = 0; obs_reward = 0;
        agent_next_action = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_env_reset", env_reset, 0);
        chk("rst_act_valid", act_valid, 0);
        chk("rst_obs_ready", obs_ready, 0);
        chk("rst_agent_en", agent_en, 0);
        chk("rst_act_data", act_data, 0);
        chk("rst_next_state", agent_next_state, 0);
        chk("rst_next_reward", agent_next_reward, 0);
        chk("rst_counts", {step_count, episode_count | goal_count}, 0);
        chk("rst_epsilon", agent_epsilon, EI);
        rst = 0;
        tick;
        chk("idle_busy", busy, 0);
        run = 1; eps = EI; steps = 0; episodes = 0; goals = 0;
        tick;
        chk("env_reset_first", env_reset, 1);
        chk("busy_run", busy, 1);
        tick;
        chk("env_reset_first_once", env_reset, 0);
        // episode 1: state 5, then a plain step, goal on step 3
        do_step(6'd5, 16'($urandom), 10);
        do_step(6'($urandom_range(0, 62)), 16'($urandom), 0);
        do_step(GS, 16'($urandom), 0);
        // episode 2: never reaches the goal, ends on the step limit
        repeat (MS) do_step(6'($urandom_range(0, 62)), 16'($urandom), $urandom_range(0, 3));
        // episodes 3 and 4: random mix of goal and non-goal states
        while (episodes < NE) begin
            do_step(($urandom % 4 == 0) ? GS : 6'($urandom_range(0, 62)), 16'($urandom), $urandom_range(0, 3));
        end
        tick;
        chk("done_hold", done, 1);
        run = 0;
        tick;
        chk("idle_done_clear", done, 0);
        chk("idle_busy_after", busy, 0);
        chk("idle_episode_hold", episode_count, episodes);
        chk("idle_goal_hold", goal_count, goals);
        // second run aborted while waiting on the agent
        run = 1;
        tick;
        chk("rerun_env_reset", env_reset, 1);
        chk("rerun_episode_clear", episode_count, 0);
        chk("rerun_goal_clear", goal_count, 0);
        chk("rerun_epsilon", agent_epsilon, EI);
        tick;
        obs_valid = 1; obs_state = 6'd7; obs_reward = 16'h1234;
        tick;
        obs_valid = 0;
        chk("rerun_agent_en", agent_en, 1);
        tick;
        run = 0;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_obs_ready", obs_ready, 0);
        repeat (6) begin
            obs_valid = 1'($urandom);
            act_ready = 1'($urandom);
            tick;
            chk("abort_act_valid", act_valid, 0);
            chk("abort_env_reset", env_reset, 0);
        end
        chk("abort_step_frozen", step_count, 0);
        chk("abort_state_frozen", agent_next_state, 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
